// File: rtl/sumador_pkg.sv
// Shared definitions for the counting-adder sequence monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sumador_pkg;

  localparam int WORD_W       = 8;
  localparam int SYNC_LEN_DEF = 4;
  localparam int LOSS_LEN_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SYNC   = 2'b01,
    ST_LOCKED = 2'b10
  } state_t;

endpackage

// File: rtl/monitor_sumador8_if.sv
// Observation bus between the counting adder and its monitor, plus monitor status.
// Latency: n/a (wires only).
// Backpressure: none; samples are qualified by enable alone.
interface monitor_sumador8_if;
  import sumador_pkg::*;

  logic              enable;
  logic [WORD_W-1:0] c;
  logic              cout;
  logic              locked;
  logic              err;
  logic [7:0]        err_count;
  logic [7:0]        wrap_count;
  logic [1:0]        state;

  modport master (
    output enable, c, cout,
    input  locked, err, err_count, wrap_count, state
  );

  modport slave (
    input  enable, c, cout,
    output locked, err, err_count, wrap_count, state
  );
endinterface

// File: rtl/sat_counter8.sv
// 8-bit event counter with synchronous clear, optionally saturating at 8'hFF.
// Latency: count updates one cycle after inc.
// Backpressure: none; inc is always accepted.
module sat_counter8 (
  input  logic       clk,
  input  logic       clr,
  input  logic       inc,
  input  logic       sat_en,
  output logic [7:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= 8'h00;
    end else if (inc && !(sat_en && (count == 8'hFF))) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/monitor_sumador8.sv
// Tracks an 8-bit counting adder's output stream, locks on it and flags sequence errors.
// Latency: all outputs registered, one cycle after the sample edge.
// Backpressure: none; every enabled sample is consumed.
module monitor_sumador8
  import sumador_pkg::*;
#(
  parameter int SYNC_LEN = SYNC_LEN_DEF,
  parameter int LOSS_LEN = LOSS_LEN_DEF
) (
  input  logic               clk,
  input  logic               rst,
  monitor_sumador8_if.slave  bus
);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] exp_q, exp_d;
  logic              prev_ff_q, prev_ff_d;
  logic [3:0]        match_cnt_q, match_cnt_d;
  logic [3:0]        miss_cnt_q, miss_cnt_d;
  logic              err_q, err_d;
  logic              wrap_inc;
  logic              in_seq;
  logic [4:0]        match_sum;
  logic [4:0]        miss_sum;

  assign in_seq    = (bus.c == exp_q) && (bus.cout == prev_ff_q);
  assign match_sum = {1'b0, match_cnt_q} + 5'd1;
  assign miss_sum  = {1'b0, miss_cnt_q} + 5'd1;

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    prev_ff_d   = prev_ff_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_d       = 1'b0;
    wrap_inc    = 1'b0;

    if (bus.enable) begin
      // Always resync to what was observed, whatever the verdict.
      exp_d     = bus.c + 8'd1;
      prev_ff_d = (bus.c == 8'hFF);

      unique case (state_q)
        ST_IDLE: begin
          match_cnt_d = 4'd1;
          state_d     = ST_SYNC;
        end
        ST_SYNC: begin
          if (in_seq) begin
            match_cnt_d = match_sum[3:0];
            if (match_sum == 5'(SYNC_LEN)) begin
              state_d    = ST_LOCKED;
              miss_cnt_d = 4'd0;
            end
          end else begin
            match_cnt_d = 4'd1;
          end
        end
        ST_LOCKED: begin
          if (in_seq) begin
            miss_cnt_d = 4'd0;
            wrap_inc   = (bus.c == 8'h00) && bus.cout;
          end else begin
            err_d      = 1'b1;
            miss_cnt_d = miss_sum[3:0];
            if (miss_sum == 5'(LOSS_LEN)) begin
              state_d     = ST_SYNC;
              match_cnt_d = 4'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      exp_q       <= '0;
      prev_ff_q   <= 1'b0;
      match_cnt_q <= 4'd0;
      miss_cnt_q  <= 4'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      prev_ff_q   <= prev_ff_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_q       <= err_d;
    end
  end

  sat_counter8 err_cnt_u (
    .clk    (clk),
    .clr    (rst),
    .inc    (err_d),
    .sat_en (1'b1),
    .count  (bus.err_count)
  );

  sat_counter8 wrap_cnt_u (
    .clk    (clk),
    .clr    (rst),
    .inc    (wrap_inc),
    .sat_en (1'b0),
    .count  (bus.wrap_count)
  );

  assign bus.locked = (state_q == ST_LOCKED);
  assign bus.err    = err_q;
  assign bus.state  = state_q;

endmodule

// File: doc/monitor_sumador8.md
MONITOR_SUMADOR8 -- requirements
Module: monitor_sumador8

Interface
REQ-001 SHALL have parameter SYNC_LEN, default 4: consecutive in-sequence samples required to declare lock (range 2..15).
REQ-002 SHALL have parameter LOSS_LEN, default 3: consecutive out-of-sequence samples, while locked, that drop lock (range 1..15).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port enable  input  1  sample strobe; c and cout are valid only when high.
REQ-006 SHALL have port c  input  8  observed 8-bit count word from the counting adder.
REQ-007 SHALL have port cout  input  1  observed carry-out accompanying c.
REQ-008 SHALL have port locked  output  1  high while in LOCKED.
REQ-009 SHALL have port err  output  1  one-cycle pulse per out-of-sequence sample.
REQ-010 SHALL have port err_count  output  8  saturating count of err pulses.
REQ-011 SHALL have port wrap_count  output  8  modulo-256 count of correct 0xFF->0x00 wraps seen while locked.
REQ-012 SHALL have port state  output  2  FSM state: IDLE=00, SYNC=01, LOCKED=10.

Function
REQ-013 SHALL keep registers exp (8 b), prev_ff (1 b), match_cnt (4 b) and miss_cnt (4 b) alongside the FSM.
REQ-014 SHALL treat a sample as in-sequence iff c == exp and cout == prev_ff; otherwise it is out-of-sequence.
REQ-015 SHALL, on every accepted sample, load exp = c + 1 (mod 256) and prev_ff = (c == 8'hFF), so tracking always resyncs to the observed value.
REQ-016 SHALL, with enable low, hold all state, counters and exp; err SHALL be 0.
REQ-017 SHALL, in IDLE, on an enabled sample: seed exp and prev_ff, set match_cnt=1, and go to SYNC; no comparison, no err.
REQ-018 SHALL, in SYNC: increment match_cnt on an in-sequence sample, and go to LOCKED with miss_cnt=0 when match_cnt reaches SYNC_LEN. On an out-of-sequence sample it SHALL set match_cnt=1 and raise no err.
REQ-019 SHALL, in LOCKED: clear miss_cnt on an in-sequence sample. On an out-of-sequence sample it SHALL pulse err, increment err_count and increment miss_cnt. When miss_cnt reaches LOSS_LEN it SHALL go to SYNC with match_cnt=1.
REQ-020 SHALL increment wrap_count, in LOCKED only, on an in-sequence sample with c==8'h00 and cout==1.
REQ-021 SHALL register all outputs: the effect of the sample at edge N is visible after edge N (one-cycle latency).
REQ-022 SHALL saturate err_count at 8'hFF; at saturation err still pulses.
REQ-023 SHALL let wrap_count wrap from 8'hFF to 8'h00 silently.
REQ-024 SHALL treat cout==1 with any c other than the expected 0x00-after-0xFF as out-of-sequence.
REQ-025 SHALL take the transition to SYNC when err and the LOSS_LEN-th miss coincide, and err SHALL still pulse that cycle.

Reset
REQ-026 SHALL, with rst high at a clock edge, take priority over enable. It SHALL force state=IDLE, locked=0, err=0, err_count=0, wrap_count=0, exp=0, prev_ff=0, match_cnt=0 and miss_cnt=0.
REQ-027 SHALL treat a reset mid-lock or mid-sync identically, with no residual state; the first enabled sample after reset re-seeds per REQ-017.

Structure
REQ-028 SHALL place the state encoding (IDLE/SYNC/LOCKED), the word width 8 and the SYNC_LEN/LOSS_LEN defaults in shared package sumador_pkg.
REQ-029 SHALL use one sub-module, sat_counter8 (8-bit counter with inc, synchronous clear and a saturate-enable), instantiated for err_count (saturating) and wrap_count (wrapping).

Verification
REQ-030 SHALL cover lock acquisition: reset, then enable with c=10,11,12,13 -> state SYNC after 10, LOCKED after 13, err never high.
REQ-031 SHALL cover wrap: locked at c=FD,FE,FF, then c=00 with cout=1 -> wrap_count=1 and no err; c=00 with cout=0 -> err pulse and err_count=1.
REQ-032 SHALL cover a single glitch: locked, stream 20,21,55,56,57 -> exactly one err at 55, miss_cnt back to 0 at 56, lock kept.
REQ-033 SHALL cover loss of lock: locked, three unrelated values 7,90,3 (LOSS_LEN=3) -> three err pulses, state SYNC after the third, err_count=3.
REQ-034 SHALL cover saturation and gating: force 260 errors -> err_count holds FF while err keeps pulsing; enable low for 5 cycles mid-stream -> no state or counter change.
REQ-035 SHALL cover reset mid-operation: assert rst while LOCKED with err_count=5 -> next cycle all outputs zero and state=00.
